// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and parity-mode constants,
// used by both the transmit framer and the receive side.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Narrower payloads are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-running counter 0..CLKS_PER_BIT-1 with a synchronous
// restart and a one-cycle bit_end tick on the last cycle of each bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word on a valid/ready handshake and
// serialises start, data (LSB first), optional parity and stop bits on tx.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state_dbg
);

  // Handshake: a word transfers on a rising edge where tx_valid && tx_ready.
  // tx_ready is high exactly while IDLE; tx_data is ignored at all other times.

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 restart;
  logic                 bit_end;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_end (bit_end)
  );

  // tx_d is the value for the next cycle, so each bit lands on the line
  // exactly on the first cycle of its bit period.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        restart = 1'b1;
        tx_d    = 1'b1;
        if (tx_valid) begin
          state_d = ST_START;
          shift_d = tx_data;
          par_d   = parity_bit(8'(tx_data), PARITY);
          idx_d   = '0;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          restart = 1'b1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          restart = 1'b1;
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          restart = 1'b1;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          restart = 1'b1;
          if (idx_q == LAST_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx        = tx_q;
  assign tx_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (434 gives 115200 baud at 50 MHz); legal values >= 2.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port tx_data, input, DATA_BITS, byte to send, sampled on acceptance.
REQ-008 SHALL have port tx_valid, input, 1, upstream has data.
REQ-009 SHALL have port tx_ready, output, 1, block can accept data.
REQ-010 SHALL have port tx, output, 1, serial line, idle high, registered.
REQ-011 SHALL have port busy, output, 1, frame in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at end of frame.

Function
REQ-013 SHALL accept a byte on any rising edge where tx_valid and tx_ready are both 1, latching tx_data into a shift register.
REQ-014 SHALL drive tx_ready high only in IDLE, dropping it on the cycle after acceptance; tx_data changes while not ready SHALL be ignored.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP: IDLE->START on acceptance; START->DATA, DATA->PARITY (PARITY!=0) or STOP after the last data bit; PARITY->STOP; STOP->IDLE after STOP_BITS stop bits.
REQ-016 SHALL drive tx low for start, data LSB first, then parity bit, then tx high for stop bits.
REQ-017 SHALL hold each bit for exactly CLKS_PER_BIT cycles, with tx changing on the first cycle after acceptance.
REQ-018 SHALL compute parity over the latched data: odd makes total ones odd, even makes it even.
REQ-019 SHALL keep busy high from the cycle after acceptance through the last stop-bit cycle, for exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-020 SHALL pulse done for one cycle on the first IDLE cycle after the frame, coincident with tx_ready rising.
REQ-021 SHALL accept a new byte on the same cycle done is high if tx_valid is high, giving back-to-back frames with no idle bit between them.
REQ-022 SHALL restart the bit counter at 0 on every state transition and never let it pass CLKS_PER_BIT-1, so the counter wraps exactly once per bit.

Reset
REQ-023 SHALL, while rst is high, force state IDLE, tx=1, tx_ready=1, busy=0, done=0, bit counter 0, bit index 0, shift register 0.
REQ-024 SHALL abort any frame in progress when rst is asserted mid-frame, with tx returning high immediately without waiting for a clock edge; no done pulse SHALL be issued for the aborted frame.
REQ-025 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Structure
REQ-026 SHALL take its state encodings (IDLE..STOP) and parity-mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2) from shared package uart_pkg, which the receive side will also use.
REQ-027 SHALL place bit timing in one sub-module, uart_bit_timer (free-running up-counter 0..CLKS_PER_BIT-1 with synchronous restart input and a one-cycle bit_end tick output), width $clog2(CLKS_PER_BIT).
REQ-028 SHALL keep the FSM, shift register and parity logic in uart_tx_framer; no further sub-modules.

Verification
REQ-029 Single frame, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, send 0xA5 -> tx is 0 (start) then 1,0,1,0,0,1,0,1 then 1 (stop), each held 4 cycles; busy high 40 cycles; done pulse once.
REQ-030 Even parity, send 0x07 -> parity bit 1; odd parity, send 0x07 -> parity bit 0; frame 44 cycles.
REQ-031 Back-to-back, tx_valid held high with 0x55 then 0xAA, STOP_BITS=2 -> second start bit begins the cycle after the first frame's final stop cycle; no extra idle high.
REQ-032 Assert rst at cycle 10 of a 0x00 frame -> tx=1 and tx_ready=1 asynchronously; no done pulse; next byte 0x3C transmits correctly after release.
REQ-033 Change tx_data mid-frame and pulse tx_valid while tx_ready=0 -> transmitted bits match the originally latched byte; the pulse is not accepted.
REQ-034 Default CLKS_PER_BIT=434, send 0xFF -> each bit is 434 cycles, frame 4340 cycles, counter never exceeds 433.
